seq_addsub_flags: RTL and testbench

- Multi-cycle, slice-serial add/subtract unit. Processes an N-bit operand pair SLICE bits per clock, rippling the carry between slices through a register.
- Produces the registered result and the 4-bit NZCV-style status word used by the existing adder datapath: bit0 V, bit1 N, bit2 Z, bit3 C.
- Sits in the ALU path wherever area matters more than single-cycle latency. Uses a start/busy/done handshake toward the control FSM.

---
 rtl/seq_addsub_flags_if.sv | 17 +
 rtl/seq_addsub_flags.sv | 110 +++++++++++
 tb/tb_seq_addsub_flags.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_addsub_flags_if.sv
// seq_addsub_flags_if: start/busy/done handshake and operand/result bus for seq_addsub_flags
// Signals: start, op[1:0], a[N-1:0], b[N-1:0], cin (requester -> unit);
//          busy, done, s[N-1:0], status[3:0] = {C,Z,N,V} (unit -> requester)
// Modports: master = requester (control FSM), slave = the add/sub unit
interface seq_addsub_flags_if #(parameter int N = 32);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] s;
   logic [3:0]   status;
   modport master (output start, op, a, b, cin, input busy, done, s, status);
   modport slave (input start, op, a, b, cin, output busy, done, s, status);
endinterface

// File: rtl/seq_addsub_flags.sv
// seq_addsub_flags: slice-serial ADD/ADC/SUB/SBC producing a registered result and {C,Z,N,V} flags
// Ports: clk, rst (async, active-high), bus (seq_addsub_flags_if.slave):
//        start/op/a/b/cin in, busy/done/s/status out; status = {C,Z,N,V}
// Optional: define SEQ_ADDSUB_SAT_EN to saturate s to signed limits on overflow
module seq_addsub_flags #(
   parameter int N     = 32,
   parameter int SLICE = 8
) (
   input logic                clk,
   input logic                rst,
   seq_addsub_flags_if.slave  bus
);
   localparam int K  = N / SLICE;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [N-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
   logic [IW-1:0] idx_q, idx_d;
   logic         carry_q, carry_d, zero_q, zero_d, done_q, done_d;
   logic [3:0]   status_q, status_d;
   logic [SLICE:0] sum;
   logic [N-1:0] res, fin;
   logic         last, z_raw, z_fin, v, a_msb;

   // Operands shift right each slice, so the current slice always sits in the low bits;
   // on the last slice the low-slice MSB is operand bit N-1.
   always_comb begin
      sum   = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
      res   = (acc_q >> SLICE) | (N'(sum[SLICE-1:0]) << (N - SLICE));
      last  = idx_q == IW'(K - 1);
      a_msb = a_q[SLICE-1];
      z_raw = zero_q & (sum[SLICE-1:0] == '0);
      v     = (a_msb == b_q[SLICE-1]) && (res[N-1] != a_msb);
`ifdef SEQ_ADDSUB_SAT_EN
      fin   = v ? (a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : res;
      z_fin = v ? (fin == '0) : z_raw;
`else
      fin   = res;
      z_fin = z_raw;
`endif
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      s_d      = s_q;
      status_d = status_q;
      if (state_q == IDLE) begin
         if (bus.start) begin
            state_d = RUN;
            a_d     = bus.a;
            b_d     = bus.b ^ {N{bus.op[1]}};
            // ADD->0, ADC->cin, SUB->1, SBC->cin; cin never selected for ADD/SUB
            carry_d = bus.op[0] ? bus.cin : bus.op[1];
            idx_d   = '0;
            acc_d   = '0;
            zero_d  = 1'b1;
         end
      end else begin
         a_d     = a_q >> SLICE;
         b_d     = b_q >> SLICE;
         acc_d   = res;
         carry_d = sum[SLICE];
         zero_d  = z_raw;
         idx_d   = idx_q + 1'b1;
         if (last) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            s_d      = fin;
            status_d = {sum[SLICE], z_fin, fin[N-1], v};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         s_q      <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         s_q      <= s_d;
         status_q <= status_d;
      end
   end

   assign bus.busy   = state_q == RUN;
   assign bus.done   = done_q;
   assign bus.s      = s_q;
   assign bus.status = status_q;
endmodule

// File: tb/tb_seq_addsub_flags.sv
// tb_seq_addsub_flags: directed self-checking bench for seq_addsub_flags (N=32, SLICE=8)
module tb_seq_addsub_flags;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;

   seq_addsub_flags_if #(.N(32)) bus ();
   seq_addsub_flags #(.N(32), .SLICE(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic ci);
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      bus.cin   = ci;
      bus.start = 1'b1;
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic ci,
                         input logic [31:0] es, input logic [3:0] est);
      drive(o, x, y, ci);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         chk({tag, "_done"}, 32'(bus.done), 32'(i == 4));
      end
      chk({tag, "_s"}, bus.s, es);
      chk({tag, "_status"}, 32'(bus.status), 32'(est));
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_s", bus.s, 32'd0);
      chk("rst_status", 32'(bus.status), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
`ifdef SEQ_ADDSUB_SAT_EN
      run_op("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h7FFFFFFF, 4'b0001);
`else
      run_op("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 4'b0011);
`endif
      run_op("sub_eq", 2'b10, 32'd5, 32'd5, 1'b0, 32'h0, 4'b1100);
      run_op("adc_rip", 2'b01, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 4'b1100);
      run_op("sbc_zero", 2'b11, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 4'b0010);
`ifdef SEQ_ADDSUB_SAT_EN
      run_op("sub_ovf", 2'b10, 32'h80000000, 32'h1, 1'b0, 32'h80000000, 4'b1011);
`else
      run_op("sub_ovf", 2'b10, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 4'b1001);
`endif
      run_op("add_carry0", 2'b00, 32'h00000100, 32'hFFFFFF00, 1'b0, 32'h0, 4'b1100);
      run_op("add_topz", 2'b00, 32'h0, 32'h01000000, 1'b0, 32'h01000000, 4'b0000);
      run_op("add_cin_ign", 2'b00, 32'h10, 32'h20, 1'b1, 32'h30, 4'b0000);
      // start pulsed mid-RUN with different operands must be ignored
      drive(2'b00, 32'd1, 32'd2, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      drive(2'b10, 32'd10, 32'd3, 1'b1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("mid_done_early", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      chk("mid_done", 32'(bus.done), 32'd1);
      chk("mid_s", bus.s, 32'd3);
      chk("mid_status", 32'(bus.status), 32'd0);
      // start in the done cycle is accepted; old result holds until the next done
      drive(2'b00, 32'h12345678, 32'h11111111, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("dc_busy", 32'(bus.busy), 32'd1);
      chk("dc_hold_s", bus.s, 32'd3);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         chk("dc_done", 32'(bus.done), 32'(i == 4));
      end
      chk("dc_s", bus.s, 32'h23456789);
      chk("dc_status", 32'(bus.status), 32'd0);
      // async reset in the middle of an operation
      drive(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_s", bus.s, 32'd0);
      chk("arst_status", 32'(bus.status), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("arst_no_done", 32'(bus.done), 32'd0);
      end
      chk("arst_s_hold", bus.s, 32'd0);
      run_op("post_rst", 2'b10, 32'd100, 32'd1, 1'b0, 32'd99, 4'b1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
